// File: rtl/seq_divider_4bit.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// start/busy/done handshake; divide-by-zero finishes in one cycle with all-ones results.
module seq_divider_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [3:0] rem_q, rem_d;
  logic [7:0] quo_q, quo_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dbz_q, dbz_d;

  logic [4:0] r_shift;
  logic       fits;
  logic [3:0] r_sub;

  // The stored partial remainder is always below the divisor, so only the shifted
  // value needs the fifth bit; the 4-bit subtraction is exact whenever fits is set.
  always_comb begin
    r_shift = {rem_q, dvd_q[7]};
    fits    = (r_shift >= {1'b0, dvs_q});
    r_sub   = r_shift[3:0] - dvs_q;
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no branch leaves one unassigned and no latch is inferred.
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (divisor == 4'd0) begin
            state_d = S_DONE;
            quo_d   = 8'hFF;
            rem_d   = 4'hF;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            dvd_d   = dividend;
            dvs_d   = divisor;
            rem_d   = 4'd0;
            quo_d   = 8'd0;
            cnt_d   = 3'd0;
            dbz_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        dvd_d = {dvd_q[6:0], 1'b0};
        quo_d = {quo_q[6:0], fits};
        rem_d = fits ? r_sub : r_shift[3:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      rem_q   <= 4'd0;
      quo_q   <= 8'd0;
      cnt_q   <= 3'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_4bit.sv
// Self-checking bench for seq_divider_4bit: cycle-level transaction model built from
// integer division, a per-cycle compare process, and directed literal checks.
module tb_seq_divider_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider_4bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Transaction model: a division is a countdown of busy cycles followed by the
  // arithmetic answer; divide-by-zero answers immediately.
  int         m_left = 0;
  logic       m_done = 1'b0;
  logic       m_dbz  = 1'b0;
  logic [7:0] m_q    = 8'd0;
  logic [3:0] m_r    = 4'd0;
  logic [7:0] p_q    = 8'd0;
  logic [3:0] p_r    = 4'd0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_left = 0;
      m_dbz  = 1'b0;
      m_q    = 8'd0;
      m_r    = 4'd0;
    end else if (m_left != 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_q    = p_q;
        m_r    = p_r;
      end
    end else if (start) begin
      if (divisor == 4'd0) begin
        m_done = 1'b1;
        m_dbz  = 1'b1;
        m_q    = 8'hFF;
        m_r    = 4'hF;
      end else begin
        m_left = 8;
        m_dbz  = 1'b0;
        p_q    = 8'(int'(dividend) / int'(divisor));
        p_r    = 4'(int'(dividend) % int'(divisor));
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
    if (m_left == 0) begin
      check("quotient", {24'd0, quotient}, {24'd0, m_q});
      check("remainder", {28'd0, remainder}, {28'd0, m_r});
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] q, output logic [3:0] r,
                         output int lat, output int busy_cycles);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    lat = 1;
    busy_cycles = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cycles++;
    end
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    q = quotient;
    r = remainder;
    check("latency", lat, (b == 4'd0) ? 32'd1 : 32'd9);
    if (b != 4'd0) begin
      check("inv_product", int'(q) * int'(b) + int'(r), {24'd0, a});
      check("inv_rem_lt_div", {31'd0, (r < b)}, 32'd1);
    end
  endtask

  task automatic div_expect(input logic [7:0] a, input logic [3:0] b,
                            input logic [7:0] eq, input logic [3:0] er, input logic edbz);
    logic [7:0] q;
    logic [3:0] r;
    int lat, bc;
    run_div(a, b, q, r, lat, bc);
    check("lit_quotient", {24'd0, q}, {24'd0, eq});
    check("lit_remainder", {28'd0, r}, {28'd0, er});
    check("lit_dbz", {31'd0, div_by_zero}, {31'd0, edbz});
  endtask

  initial begin
    logic [7:0] q;
    logic [3:0] r;
    int lat, bc, cyc, n_done;
    int done_at[3];

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_quotient", {24'd0, quotient}, 32'd0);
    check("reset_remainder", {28'd0, remainder}, 32'd0);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);

    // Basic 200/7 with latency and busy length
    run_div(8'd200, 4'd7, q, r, lat, bc);
    check("q_200_7", {24'd0, q}, 32'd28);
    check("r_200_7", {28'd0, r}, 32'd4);
    check("busy_len_200_7", bc, 32'd8);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    div_expect(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
    div_expect(8'd15, 4'd15, 8'd1, 4'd0, 1'b0);
    div_expect(8'd0, 4'd5, 8'd0, 4'd0, 1'b0);
    div_expect(8'd7, 4'd9, 8'd0, 4'd7, 1'b0);

    // Divide by zero, then recovery
    run_div(8'd100, 4'd0, q, r, lat, bc);
    check("q_div0", {24'd0, q}, 32'hFF);
    check("r_div0", {28'd0, r}, 32'hF);
    check("dbz_div0", {31'd0, div_by_zero}, 32'd1);
    check("busy_div0", bc, 32'd0);
    div_expect(8'd100, 4'd10, 8'd10, 4'd0, 1'b0);

    // Start during RUN is ignored
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    check("ignored_start_done", {31'd0, done}, 32'd1);
    check("ignored_start_q", {24'd0, quotient}, 32'd28);
    check("ignored_start_r", {28'd0, remainder}, 32'd4);

    // Start held high: one done every 9 cycles
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    n_done = 0;
    for (int c = 0; c < 40 && n_done < 3; c++) begin
      @(negedge clk);
      if (done) begin
        done_at[n_done] = c;
        n_done++;
        check("cont_q", {24'd0, quotient}, 32'd28);
        check("cont_r", {28'd0, remainder}, 32'd4);
      end
    end
    start = 1'b0;
    check("cont_pulses", n_done, 32'd3);
    if (n_done == 3) begin
      check("cont_gap1", done_at[1] - done_at[0], 32'd9);
      check("cont_gap2", done_at[2] - done_at[1], 32'd9);
    end
    repeat (12) @(negedge clk);

    // Reset in cycle 5 of RUN
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outputs", {quotient, remainder, busy, done, div_by_zero}, 32'd0);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst_no_done", n_done, 32'd0);
    div_expect(8'd63, 4'd8, 8'd7, 4'd7, 1'b0);

    // Randomised traffic including div-by-zero, mid-run starts and resets
    for (int c = 0; c < 3000; c++) begin
      start    = ($urandom_range(0, 3) == 0);
      dividend = 8'($urandom);
      divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      rst      = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
    repeat (12) @(negedge clk);

    // Multiplier round trip
    for (int a = 1; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_div(8'(a * b), 4'(b), q, r, lat, bc);
        check("rt_quotient", {24'd0, q}, a);
        check("rt_remainder", {28'd0, r}, 32'd0);
      end
    end

    // Exhaustive sweep, back to back
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(8'(a), 4'(b), q, r, lat, bc);
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
